instruction_fetch: RTL and testbench

Fetch stage between the program counter and the decoder. Reads one instruction of `INST_W_BYTES` bytes from a byte-wide, synchronous instruction memory starting at the current `pc`, assembling the bytes little-endian. Presents the instruction with a valid/ready handshake. Pulses `pc_advance` when the decoder accepts, and discards in-flight work on `flush` (branch redirect).

---
 rtl/instruction_fetch.sv | 95 +++++++++
 tb/tb_instruction_fetch.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: reads an instruction one byte per cycle from a byte-wide synchronous
// memory, assembles it little-endian and hands it to the decoder over valid/ready.
module instruction_fetch #(
    parameter int I_ADDR_W     = 12,
    parameter int INST_W_BYTES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [I_ADDR_W-1:0]       pc,
    input  logic                      flush,
    output logic                      imem_req,
    output logic [I_ADDR_W-1:0]       imem_addr,
    input  logic [7:0]                imem_rdata,
    output logic [8*INST_W_BYTES-1:0] instr,
    output logic [I_ADDR_W-1:0]       instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic                      pc_advance
);
    localparam int CW = INST_W_BYTES > 1 ? $clog2(INST_W_BYTES) : 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LAST  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;
    localparam logic [CW-1:0] LAST_CNT = CW'(INST_W_BYTES - 1);

    logic [1:0]                state_q, state_d;
    logic [CW-1:0]             req_cnt_q, req_cnt_d;
    logic [CW-1:0]             resp_idx_q, resp_idx_d;
    logic                      resp_vld_q, resp_vld_d;
    logic [I_ADDR_W-1:0]       base_q, base_d;
    logic [I_ADDR_W-1:0]       instr_pc_q, instr_pc_d;
    logic [8*INST_W_BYTES-1:0] instr_q, instr_d;

    assign imem_req    = state_q == FETCH;
    assign imem_addr   = !imem_req ? '0 : req_cnt_q == '0 ? pc : base_q + I_ADDR_W'(req_cnt_q);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = state_q == HOLD;
    assign pc_advance  = instr_valid & instr_ready & ~flush;

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        base_d     = base_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;
        // a response is tracked only for requests not cancelled by a redirect
        resp_vld_d = imem_req & ~flush;
        resp_idx_d = req_cnt_q;
        if (imem_req && req_cnt_q == '0)
            base_d = pc;
        if (resp_vld_q && !flush)
            for (int k = 0; k < INST_W_BYTES; k++)
                if (resp_idx_q == CW'(k))
                    instr_d[8*k +: 8] = imem_rdata;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (req_cnt_q == LAST_CNT) state_d = LAST;
                     else req_cnt_d = req_cnt_q + 1'b1;
            LAST:    begin
                         state_d    = HOLD;
                         instr_pc_d = base_q;
                     end
            default: if (instr_ready) begin
                         state_d   = FETCH;
                         req_cnt_d = '0;
                     end
        endcase
        if (flush) begin
            state_d   = FETCH;
            req_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_cnt_q  <= '0;
            resp_idx_q <= '0;
            resp_vld_q <= 1'b0;
            base_q     <= '0;
            instr_pc_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            resp_idx_q <= resp_idx_d;
            resp_vld_q <= resp_vld_d;
            base_q     <= base_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios against a byte-wide synchronous memory model.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pc = '0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_advance;
    logic [7:0]  mem [0:4095];
    int          checks = 0;
    int          errors = 0;

    instruction_fetch #(.I_ADDR_W(12), .INST_W_BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc_advance(pc_advance)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_req) imem_rdata <= mem[imem_addr];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            pc = 12'($urandom); flush = 1'($urandom); instr_ready = 1'($urandom);
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", imem_req); end
            checks++; if (imem_addr !== 12'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
            checks++; if (instr !== 16'h0) begin errors++; $display("FAIL rst_instr got=%0h exp=0", instr); end
            checks++; if (instr_pc !== 12'h0) begin errors++; $display("FAIL rst_instr_pc got=%0h exp=0", instr_pc); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
            checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL rst_adv got=%0h exp=0", pc_advance); end
        end
        tick();
        rst_n = 1'b1; pc = 12'h010; flush = 1'b0; instr_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%0h exp=0", imem_req); end
        tick();
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%0h exp=1", imem_req); end
        checks++; if (imem_addr !== 12'h010) begin errors++; $display("FAIL first_addr got=%0h exp=010", imem_addr); end
    endtask

    task automatic test_basic();
        tick(); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h011) begin errors++; $display("FAIL basic_req1 got=%0h/%0h exp=1/011", imem_req, imem_addr); end
        tick(); #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_last got=%0h/%0h exp=0/0", imem_req, instr_valid); end
        tick(); #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr !== 16'h1234) begin errors++; $display("FAIL basic_instr got=%0h exp=1234", instr); end
        checks++; if (instr_pc !== 12'h010) begin errors++; $display("FAIL basic_instr_pc got=%0h exp=010", instr_pc); end
        checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL basic_adv got=%0h exp=1", pc_advance); end
        tick();
        pc = 12'h020; instr_ready = 1'b0;
        #1;
        checks++; if (pc_advance !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_adv_pulse got=%0h/%0h exp=0/0", pc_advance, instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h020) begin errors++; $display("FAIL basic_next_req got=%0h/%0h exp=1/020", imem_req, imem_addr); end
    endtask

    task automatic test_backpressure();
        tick(); #1;
        checks++; if (imem_addr !== 12'h021) begin errors++; $display("FAIL bp_req1 got=%0h exp=021", imem_addr); end
        tick(); #1;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got=%0h exp=1", i, instr_valid); end
            checks++; if (instr !== 16'h5678) begin errors++; $display("FAIL bp_instr%0d got=%0h exp=5678", i, instr); end
            checks++; if (instr_pc !== 12'h020) begin errors++; $display("FAIL bp_instr_pc%0d got=%0h exp=020", i, instr_pc); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req%0d got=%0h exp=0", i, imem_req); end
            checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL bp_adv%0d got=%0h exp=0", i, pc_advance); end
        end
        tick();
        instr_ready = 1'b1;
        #1;
        checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL bp_accept got=%0h exp=1", pc_advance); end
        tick();
        pc = 12'hFFF;
        #1;
        checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL bp_adv_single got=%0h exp=0", pc_advance); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'hFFF) begin errors++; $display("FAIL bp_next_req got=%0h/%0h exp=1/fff", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        tick(); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin errors++; $display("FAIL wrap_addr got=%0h/%0h exp=1/000", imem_req, imem_addr); end
        tick(); #1;
        tick(); #1;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr !== 16'hABCD) begin errors++; $display("FAIL wrap_instr got=%0h exp=abcd", instr); end
        checks++; if (instr_pc !== 12'hFFF) begin errors++; $display("FAIL wrap_instr_pc got=%0h exp=fff", instr_pc); end
        tick();
        pc = 12'h100;
        #1;
        checks++; if (imem_addr !== 12'h100) begin errors++; $display("FAIL wrap_next got=%0h exp=100", imem_addr); end
    endtask

    task automatic test_flush();
        tick();
        flush = 1'b1; pc = 12'h200;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h101) begin errors++; $display("FAIL fl_cur_req got=%0h/%0h exp=1/101", imem_req, imem_addr); end
        checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL fl_adv got=%0h exp=0", pc_advance); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h200) begin errors++; $display("FAIL fl_refetch got=%0h/%0h exp=1/200", imem_req, imem_addr); end
        tick(); #1;
        checks++; if (imem_addr !== 12'h201) begin errors++; $display("FAIL fl_req1 got=%0h exp=201", imem_addr); end
        tick(); #1;
        checks++; if (instr_valid !== 1'b0 || pc_advance !== 1'b0) begin errors++; $display("FAIL fl_no_adv got=%0h/%0h exp=0/0", instr_valid, pc_advance); end
        tick();
        flush = 1'b1; pc = 12'h300;
        #1;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h3344 || instr_pc !== 12'h200) begin errors++; $display("FAIL fl_new_instr got=%0h/%0h/%0h exp=1/3344/200", instr_valid, instr, instr_pc); end
        checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL fl_accept_adv got=%0h exp=0", pc_advance); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_drop got=%0h exp=0", instr_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h300) begin errors++; $display("FAIL fl_after got=%0h/%0h exp=1/300", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid();
        tick(); #1;
        tick(); #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rm_last got=%0h/%0h exp=0/0", imem_req, instr_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (instr !== 16'h0 || instr_pc !== 12'h0) begin errors++; $display("FAIL rm_async got=%0h/%0h exp=0/0", instr, instr_pc); end
        checks++; if (imem_req !== 1'b0 || imem_addr !== 12'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rm_ctrl got=%0h/%0h/%0h exp=0/0/0", imem_req, imem_addr, instr_valid); end
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_idle got=%0h exp=0", imem_req); end
        tick(); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h300) begin errors++; $display("FAIL rm_req0 got=%0h/%0h exp=1/300", imem_req, imem_addr); end
        tick(); #1;
        tick(); #1;
        tick(); #1;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h5566 || instr_pc !== 12'h300) begin errors++; $display("FAIL rm_instr got=%0h/%0h/%0h exp=1/5566/300", instr_valid, instr, instr_pc); end
        checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL rm_adv got=%0h exp=1", pc_advance); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'h34; mem[12'h011] = 8'h12;
        mem[12'h020] = 8'h78; mem[12'h021] = 8'h56;
        mem[12'hFFF] = 8'hCD; mem[12'h000] = 8'hAB;
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22;
        mem[12'h200] = 8'h44; mem[12'h201] = 8'h33;
        mem[12'h300] = 8'h66; mem[12'h301] = 8'h55;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
